// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and FSM state type for the LED color judge
package led_pkg;
    localparam int CW = 8;
    localparam logic [CW-1:0] THRESH_DEF = 8'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_CALC,
        S_DONE
    } state_t;
endpackage

// File: rtl/chan_avg.sv
// rtl/chan_avg.sv - per-channel accumulator, window average and change-threshold compare
module chan_avg
    import led_pkg::*;
#(
    parameter int             PIX_LOG2 = 10,
    parameter logic [CW-1:0]  THRESH   = THRESH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          add,
    input  logic [CW-1:0] pix,
    input  logic [CW-1:0] ref_c,
    output logic [CW-1:0] avg,
    output logic          exceed
);
    localparam int SW = CW + PIX_LOG2;

    logic [SW-1:0] sum;
    logic [CW-1:0] diff;

    // clr with add loads the coincident pixel as the first of a new window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clr) begin
            sum <= add ? SW'(pix) : '0;
        end else if (add) begin
            sum <= sum + SW'(pix);
        end
    end

    always_comb begin
        avg    = sum[SW-1:PIX_LOG2];
        diff   = (avg >= ref_c) ? (avg - ref_c) : (ref_c - avg);
        exceed = (diff > THRESH);
    end
endmodule

// File: rtl/color_judge.sv
// rtl/color_judge.sv - frame color averaging and change detection driving the LED refresh gate
module color_judge
    import led_pkg::*;
#(
    parameter int             PIX_LOG2 = 10,
    parameter logic [CW-1:0]  THRESH   = THRESH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof,
    input  logic          pix_vld,
    input  logic [CW-1:0] pix_r,
    input  logic [CW-1:0] pix_g,
    input  logic [CW-1:0] pix_b,
    output logic [CW-1:0] avg_r,
    output logic [CW-1:0] avg_g,
    output logic [CW-1:0] avg_b,
    output logic          judge,
    output logic          finish,
    output logic          busy
);
    localparam int             CNTW = PIX_LOG2 + 1;
    localparam logic [CNTW-1:0] NPIX = CNTW'(1) << PIX_LOG2;

    state_t          state, state_n;
    logic [CNTW-1:0] cnt, cnt_n;
    logic            pend, pend_n;
    logic            first;
    logic            clr, add;
    logic            judge_n;
    logic [CW-1:0]   ref_r, ref_g, ref_b;
    logic [CW-1:0]   ca_r, ca_g, ca_b;
    logic            ex_r, ex_g, ex_b;

    chan_avg #(.PIX_LOG2(PIX_LOG2), .THRESH(THRESH)) u_r (
        .clk(clk), .rst(rst), .clr(clr), .add(add), .pix(pix_r),
        .ref_c(ref_r), .avg(ca_r), .exceed(ex_r)
    );
    chan_avg #(.PIX_LOG2(PIX_LOG2), .THRESH(THRESH)) u_g (
        .clk(clk), .rst(rst), .clr(clr), .add(add), .pix(pix_g),
        .ref_c(ref_g), .avg(ca_g), .exceed(ex_g)
    );
    chan_avg #(.PIX_LOG2(PIX_LOG2), .THRESH(THRESH)) u_b (
        .clk(clk), .rst(rst), .clr(clr), .add(add), .pix(pix_b),
        .ref_c(ref_b), .avg(ca_b), .exceed(ex_b)
    );

    assign judge_n = first | ex_r | ex_g | ex_b;
    assign busy    = (state != S_IDLE);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        clr     = 1'b0;
        add     = 1'b0;
        case (state)
            S_IDLE: begin
                if (sof || pend) begin
                    state_n = S_ACC;
                    clr     = 1'b1;
                    add     = sof && pix_vld;
                    cnt_n   = CNTW'(sof && pix_vld);
                    pend_n  = 1'b0;
                end
            end
            S_ACC: begin
                if (sof) begin
                    clr   = 1'b1;
                    add   = pix_vld;
                    cnt_n = CNTW'(pix_vld);
                end else if (pix_vld) begin
                    add   = 1'b1;
                    cnt_n = cnt + CNTW'(1);
                end
            end
            S_CALC: begin
                state_n = S_DONE;
                if (sof) pend_n = 1'b1;
            end
            S_DONE: begin
                if (sof || pend) begin
                    state_n = S_ACC;
                    clr     = 1'b1;
                    cnt_n   = '0;
                    pend_n  = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // the pixel that completes the window moves straight to CALC
        if (add && cnt_n == NPIX) state_n = S_CALC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            pend   <= 1'b0;
            first  <= 1'b1;
            ref_r  <= '0;
            ref_g  <= '0;
            ref_b  <= '0;
            avg_r  <= '0;
            avg_g  <= '0;
            avg_b  <= '0;
            judge  <= 1'b0;
            finish <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            pend   <= pend_n;
            finish <= (state == S_DONE);
            if (state == S_DONE) begin
                judge <= judge_n;
                avg_r <= ca_r;
                avg_g <= ca_g;
                avg_b <= ca_b;
                // reference follows only colors actually forwarded to the LEDs
                if (judge_n) begin
                    ref_r <= ca_r;
                    ref_g <= ca_g;
                    ref_b <= ca_b;
                    first <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_color_judge.sv
// tb/tb_color_judge.sv - self-checking bench for color_judge with a frame-level reference model
module tb_color_judge;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sof = 1'b0;
    logic       pix_vld = 1'b0;
    logic [7:0] pix_r = '0, pix_g = '0, pix_b = '0;
    logic [7:0] avg_r, avg_g, avg_b;
    logic       judge, finish, busy;

    int checks = 0;
    int errors = 0;

    int fr_r[4], fr_g[4], fr_b[4];
    int m_ref[3];
    bit m_first;

    color_judge #(.PIX_LOG2(2), .THRESH(8'd8)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_vld(pix_vld),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .avg_r(avg_r), .avg_g(avg_g), .avg_b(avg_b),
        .judge(judge), .finish(finish), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input int r, input int g, input int b);
        for (int i = 0; i < 4; i++) begin
            fr_r[i] = r; fr_g[i] = g; fr_b[i] = b;
        end
    endtask

    task automatic junk_pix();
        pix_r = 8'($urandom); pix_g = 8'($urandom); pix_b = 8'($urandom);
    endtask

    task automatic drive_pix(input int i);
        pix_r = 8'(fr_r[i]); pix_g = 8'(fr_g[i]); pix_b = 8'(fr_b[i]);
    endtask

    task automatic send_pixels(input bit lead_sof, input bit coincide, input bit gaps);
        int i;
        i = 0;
        if (lead_sof) begin
            sof = 1'b1;
            if (coincide) begin
                pix_vld = 1'b1; drive_pix(0); i = 1;
            end else begin
                pix_vld = 1'b0; junk_pix();
            end
            tick();
            sof = 1'b0;
        end
        while (i < 4) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                pix_vld = 1'b0; junk_pix();
                tick();
            end else begin
                pix_vld = 1'b1; drive_pix(i);
                tick();
                i++;
            end
        end
        pix_vld = 1'b0;
    endtask

    // mode 0: frame ends to idle; 1: sof in the DONE cycle; 2: sof in the CALC cycle
    task automatic finish_frame(input string tag, input int mode);
        int sum[3];
        int av[3];
        int d;
        bit jn;
        sum = '{0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            sum[0] += fr_r[i]; sum[1] += fr_g[i]; sum[2] += fr_b[i];
        end
        jn = m_first;
        for (int c = 0; c < 3; c++) begin
            av[c] = sum[c] / 4;
            d = (av[c] > m_ref[c]) ? av[c] - m_ref[c] : m_ref[c] - av[c];
            if (d > 8) jn = 1'b1;
        end
        if (mode == 2) sof = 1'b1;
        tick();
        sof = 1'b0;
        chk({tag, ".finish_early"}, 32'(finish), 0);
        if (mode == 1) sof = 1'b1;
        tick();
        sof = 1'b0;
        chk({tag, ".finish"}, 32'(finish), 1);
        chk({tag, ".avg_r"}, 32'(avg_r), av[0]);
        chk({tag, ".avg_g"}, 32'(avg_g), av[1]);
        chk({tag, ".avg_b"}, 32'(avg_b), av[2]);
        chk({tag, ".judge"}, 32'(judge), 32'(jn));
        if (jn) begin
            m_ref = av;
            m_first = 1'b0;
        end
        if (mode == 0) begin
            tick();
            chk({tag, ".finish_fall"}, 32'(finish), 0);
            chk({tag, ".busy_idle"}, 32'(busy), 0);
        end else begin
            chk({tag, ".busy_next"}, 32'(busy), 1);
        end
    endtask

    task automatic model_reset();
        m_ref = '{0, 0, 0};
        m_first = 1'b1;
    endtask

    function automatic int clamp8(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    initial begin
        model_reset();
        tick();
        chk("rst.avg_r", 32'(avg_r), 0);
        chk("rst.judge", 32'(judge), 0);
        chk("rst.finish", 32'(finish), 0);
        chk("rst.busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        tick();

        set_frame(100, 50, 20);
        send_pixels(1, 0, 0);
        finish_frame("first", 0);

        set_frame(105, 50, 20);
        send_pixels(1, 0, 0);
        finish_frame("small", 0);

        set_frame(109, 50, 20);
        fr_r[0] = 108;
        send_pixels(1, 0, 0);
        finish_frame("drift_trunc", 0);

        set_frame(109, 50, 20);
        send_pixels(1, 0, 0);
        finish_frame("drift_cross", 0);

        sof = 1'b1; tick(); sof = 1'b0;
        for (int i = 0; i < 2; i++) begin
            pix_vld = 1'b1; pix_r = 8'd200; pix_g = 8'd200; pix_b = 8'd200;
            tick();
            chk("abort.no_finish", 32'(finish), 0);
        end
        set_frame(0, 0, 0);
        send_pixels(1, 1, 0);
        finish_frame("abort", 0);

        set_frame(30, 40, 50);
        send_pixels(1, 0, 0);
        finish_frame("b2b_done_a", 1);
        set_frame(200, 40, 50);
        send_pixels(0, 0, 0);
        finish_frame("b2b_done_b", 2);
        set_frame(60, 90, 120);
        send_pixels(0, 0, 0);
        finish_frame("b2b_calc", 0);

        for (int f = 0; f < 16; f++) begin
            bit wide;
            wide = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) begin
                if (wide) begin
                    fr_r[i] = $urandom_range(0, 255);
                    fr_g[i] = $urandom_range(0, 255);
                    fr_b[i] = $urandom_range(0, 255);
                end else begin
                    fr_r[i] = clamp8(m_ref[0] + int'($urandom_range(0, 24)) - 12);
                    fr_g[i] = clamp8(m_ref[1] + int'($urandom_range(0, 24)) - 12);
                    fr_b[i] = clamp8(m_ref[2] + int'($urandom_range(0, 24)) - 12);
                end
            end
            repeat ($urandom_range(0, 2)) begin
                pix_vld = 1'($urandom); junk_pix();
                tick();
            end
            pix_vld = 1'b0;
            send_pixels(1, 1'($urandom), 1'($urandom));
            finish_frame($sformatf("rand%0d", f), 0);
        end

        set_frame(180, 170, 160);
        send_pixels(1, 0, 0);
        finish_frame("pre_rst", 0);
        sof = 1'b1; tick(); sof = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_vld = 1'b1; junk_pix(); tick();
        end
        pix_vld = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst.avg_r", 32'(avg_r), 0);
        chk("midrst.avg_g", 32'(avg_g), 0);
        chk("midrst.avg_b", 32'(avg_b), 0);
        chk("midrst.judge", 32'(judge), 0);
        chk("midrst.busy", 32'(busy), 0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        set_frame(3, 3, 3);
        send_pixels(1, 0, 0);
        finish_frame("post_rst_first", 0);
        send_pixels(1, 0, 1);
        finish_frame("post_rst_second", 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/color_judge.md
# color_judge

Frame-level color change detector feeding the LED update gate. Accumulates a window of 2^PIX_LOG2 RGB pixels per frame and averages each channel. Compares the averages against the last color sent to the LEDs. Produces the `finish` pulse and `judge` level that the downstream AND stage combines into the LED refresh trigger.

## Interface
Parameters:
- `PIX_LOG2`, default 10. log2 of pixels averaged per frame; the bench uses 2.
- `THRESH`, default 8. Per-channel change threshold, 8-bit, compared strictly greater-than.

Ports:
- `clk`: input, 1 bit. The only clock. All logic is on its rising edge.
- `rst`: input, 1 bit. Asynchronous, active-high reset.
- `sof`: input, 1 bit. Start-of-frame pulse, one cycle.
- `pix_vld`: input, 1 bit. Pixel valid. No backpressure.
- `pix_r`, `pix_g`, `pix_b`: input, 8 bits each. Pixel channels, sampled when `pix_vld`=1.
- `avg_r`, `avg_g`, `avg_b`: output, 8 bits each. Latest frame averages.
- `judge`: output, 1 bit. Level. 1 when the latest frame differs from the reference color.
- `finish`: output, 1 bit. One-cycle pulse at the end of each completed frame.
- `busy`: output, 1 bit. High in ACC, CALC and DONE.

## Operation
- FSM states: IDLE, ACC, CALC, DONE.
- On reset:
  - State = IDLE.
  - Accumulators, pixel count, avg_*, the reference registers ref_r/g/b, `judge`, `finish`, `busy` and `pend` are all 0.
  - `first` = 1.
- **IDLE**
  - When `sof`=1 (or `pend`=1): clear the three sums and the count, clear `pend`, go to ACC.
  - `pix_vld` is ignored unless `sof` is asserted in the same cycle.
- **ACC**
  - On each `pix_vld`, add each channel to its sum and increment the count.
  - Sum width is 8+PIX_LOG2; it cannot overflow.
  - When the pixel accepted is number 2^PIX_LOG2, go to CALC.
  - `sof` in ACC aborts the frame: sums and count are cleared, the state stays ACC, no `finish` is produced.
  - If `sof` and `pix_vld` coincide, that pixel is pixel 1 of the new frame.
- **CALC**
  - Compute avg_c = sum_c >> PIX_LOG2 (truncating) for each channel.
  - Compute d_c = |avg_c − ref_c| as 8-bit unsigned.
  - Evaluate judge_n = `first` OR (d_r > THRESH) OR (d_g > THRESH) OR (d_b > THRESH).
  - Go to DONE.
- **DONE**
  - `finish` = 1, `judge` = judge_n, avg_* are updated. All three are registered and change on the same edge.
  - If judge_n = 1: ref_* ← avg_* and `first` ← 0.
  - The reference tracks the last color forwarded to the LEDs, so slow drift accumulates until it crosses THRESH.
  - Next state is ACC if a `sof` arrived in CALC or DONE, otherwise IDLE.
  - A `sof` arriving in DONE goes to ACC directly with a cleared accumulator. A `sof` arriving in CALC sets `pend`.
- `judge` holds its value until the next DONE.
- `pix_vld` in CALC and DONE is dropped.

## Timing
- Edge E samples the last pixel; the FSM is in CALC for the following cycle.
- `finish`, `judge` and avg_* become valid after edge E+2, together in the same cycle. `finish` falls after E+3.
- Minimum frame-to-frame spacing: 2^PIX_LOG2 + 2 cycles, with `sof` back-to-back with DONE.
- `rst` asserted mid-frame clears everything immediately, including `first`. The next frame is then treated as first and forces `judge`=1.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package `led_pkg`:
  - Channel width constant `CW`=8.
  - FSM state enum.
  - Default `THRESH`.
- Sub-module `chan_avg`, instantiated three times, one per channel. It holds the accumulator, the shift-average, the absolute difference against ref and the threshold compare, and outputs avg plus an exceed bit.
- Top level: FSM, pixel count, `first`/`pend` flags, output registers.

## Test plan
All scenarios use PIX_LOG2=2 and THRESH=8.
- **Reset, then first frame.** `sof`, 4 pixels of (100,50,20) → `finish` pulses 2 cycles after the 4th pixel; avg=(100,50,20); `judge`=1 (first).
- **Small change.** Next frame with 4 pixels of (105,50,20) → `judge`=0; ref stays (100,50,20); avg=(105,50,20).
- **Drift and truncation.**
  - Next frame with pixels 108, 109, 109, 109 on R, G/B unchanged → sum 435, avg_r=108, d_r=8, `judge`=0.
  - Then a frame of 109 on R → d_r=9, `judge`=1; ref_r becomes 109.
- **Abort.** `sof` after 2 pixels, then a full 4-pixel frame of (0,0,0) → exactly one `finish`; avg=(0,0,0); `judge`=1.
- **Back-to-back.**
  - `sof` arrives in the DONE cycle; its 4 pixels follow immediately → second `finish` appears 6 cycles after the first.
  - `sof` arrives in the CALC cycle → `pend` is set and the frame still completes.
- **Mid-frame reset.** Assert `rst` in ACC after 3 pixels → all outputs 0 immediately. The next full frame gives `judge`=1 regardless of color.
